pixel_row_writer: RTL

Downstream stage of the RGB565 pixel packer. Consumes the packed 32-bit pixel-pair words (low half = left pixel, high half = right pixel; upper half zero for an odd final pixel). Writes them row by row into the frame buffer through a write-only Avalon-MM style master, using a programmed base address, row stride, width and height. A small FIFO decouples the packer from memory back-pressure; `done` pulses when the last word of the frame has been accepted by memory.

---
 rtl/pixel_row_writer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/pixel_row_writer.sv
// Writes packed RGB565 pixel-pair words row by row into a frame buffer through a
// write-only Avalon-MM style master, with a small input FIFO absorbing memory stalls.
//
// state | meaning
// IDLE  | waiting for start, config may be latched
// RUN   | accepting frame words from the packer and writing them out
// DRAIN | all words accepted, emptying FIFO and output command register
// DONE  | one-cycle completion pulse
module pixel_row_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int DIM_W      = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [15:0]      stride,
  input  logic [DIM_W-1:0] width,
  input  logic [DIM_W-1:0] height,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic [31:0]      wr_address,
  output logic [31:0]      wr_writedata,
  output logic [3:0]       wr_byteenable,
  output logic             wr_write,
  input  logic             wr_waitrequest
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = 2 * DIM_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state;
  logic [15:0]      stride_q;
  logic [DIM_W-1:0] wpr_q;
  logic             odd_q;
  logic [FW-1:0]    frame_words;
  logic [FW-1:0]    acc_cnt;
  logic [31:0]      row_addr;
  logic [DIM_W-1:0] col;

  logic [31:0]      fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;

  logic [DIM_W-1:0] wpr_new;
  logic [FW-1:0]    frame_new;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             pop;
  logic             fifo_wr;
  logic             wr_accept;
  logic             load;
  logic             last_col;
  logic [31:0]      load_data;

  assign wpr_new   = {1'b0, width[DIM_W-1:1]} + DIM_W'(width[0]);
  assign frame_new = FW'(wpr_new) * FW'(height);

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));

  // in_ready looks only at registered occupancy, so a pop does not open a slot the same cycle
  assign in_ready  = (state == S_RUN) && !fifo_full && (acc_cnt < frame_words);
  assign push      = in_valid && in_ready;
  assign wr_accept = wr_write && !wr_waitrequest;

  // An empty FIFO lets the incoming word go straight into the command register
  assign load      = (!wr_write || !wr_waitrequest) && (!fifo_empty || push);
  assign pop       = load && !fifo_empty;
  assign fifo_wr   = push && !(load && fifo_empty);
  assign load_data = fifo_empty ? in_data : fifo_mem[rd_ptr];
  assign last_col  = (col == wpr_q - DIM_W'(1));

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      stride_q      <= '0;
      wpr_q         <= '0;
      odd_q         <= 1'b0;
      frame_words   <= '0;
      acc_cnt       <= '0;
      row_addr      <= '0;
      col           <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      wr_address    <= '0;
      wr_writedata  <= '0;
      wr_byteenable <= '0;
      wr_write      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            stride_q    <= stride;
            wpr_q       <= wpr_new;
            odd_q       <= width[0];
            frame_words <= frame_new;
            acc_cnt     <= '0;
            row_addr    <= base_addr;
            col         <= '0;
            state       <= (width == '0 || height == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (push && (acc_cnt == frame_words - FW'(1))) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (fifo_empty && wr_accept) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (push) acc_cnt <= acc_cnt + FW'(1);

      if (fifo_wr) begin
        fifo_mem[wr_ptr] <= in_data;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(fifo_wr) - (AW+1)'(pop);

      // Row start address is accumulated by stride; modulo-2^32 wrap is intended
      if (load) begin
        wr_write      <= 1'b1;
        wr_address    <= row_addr + (32'(col) << 2);
        wr_writedata  <= load_data;
        wr_byteenable <= (last_col && odd_q) ? 4'b0011 : 4'b1111;
        if (last_col) begin
          col      <= '0;
          row_addr <= row_addr + {16'h0000, stride_q};
        end else begin
          col <= col + DIM_W'(1);
        end
      end else if (wr_accept) begin
        wr_write <= 1'b0;
      end
    end
  end

endmodule
